// File: rtl/effect_pkg.sv
// Shared mode and state encodings for the effect router and its bench.
package effect_pkg;

    typedef enum logic [1:0] {
        BYPASS = 2'b00,
        FILTER = 2'b01,
        ECHO   = 2'b10,
        MUTE   = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        FADE = 1'b1
    } state_e;

endpackage

// File: rtl/echo_delay.sv
// DEPTH-sample circular delay line; output is masked to zero until the
// buffer has been completely written once after reset.
module echo_delay #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 1024
) (
    input  logic             sample_clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic             fill_q, fill_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q + 1'b1;
        fill_d   = fill_q | (wr_ptr_q == AW'(DEPTH - 1));
    end

    always_ff @(posedge sample_clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            fill_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // RAM has no reset; stale contents are hidden by fill_q.
    always_ff @(posedge sample_clock) begin
        mem[wr_ptr_q] <= din;
    end

    assign dout = fill_q ? mem[wr_ptr_q] : '0;

endmodule

// File: rtl/effect_router.sv
// Selects bypass/filter/echo/mute paths with a linear crossfade between
// modes; the output is registered one sample after its inputs.
module effect_router
    import effect_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int DEPTH      = 1024,
    parameter int FADE_LOG2  = 4,
    parameter int ECHO_SHIFT = 1
) (
    input  logic             sample_clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] input_sample,
    input  logic [WIDTH-1:0] filter_sample,
    input  logic [1:0]       selector,
    output logic [WIDTH-1:0] output_sample,
    output logic [1:0]       mode_active,
    output logic             fading
);

    localparam int PW = WIDTH + FADE_LOG2 + 2;
    localparam logic signed [FADE_LOG2+1:0] FADE_W =
        (FADE_LOG2 + 2)'(2 ** FADE_LOG2);
    localparam logic [FADE_LOG2-1:0] K_LAST = '1;

    state_e                  state_q, state_d;
    mode_e                   mode_q, mode_d;
    mode_e                   target_q, target_d;
    mode_e                   pend_q, pend_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [FADE_LOG2-1:0]    k_q, k_d;
    logic signed [WIDTH-1:0] out_q, out_d;

    logic [WIDTH-1:0]        dly_raw;
    logic signed [WIDTH-1:0] in_s, flt_s, dly_s, dly_sh, echo_s;
    logic signed [WIDTH:0]   echo_sum;
    logic signed [WIDTH-1:0] cur_s, new_s, mix_s;
    logic signed [FADE_LOG2+1:0] wn, wo;
    logic signed [PW-1:0]    mix;
    mode_e                   req;

    echo_delay #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_delay (
        .sample_clock (sample_clock),
        .reset        (reset),
        .din          (input_sample),
        .dout         (dly_raw)
    );

    function automatic logic signed [WIDTH-1:0] path_mux(
        input mode_e                   m,
        input logic signed [WIDTH-1:0] byp,
        input logic signed [WIDTH-1:0] flt,
        input logic signed [WIDTH-1:0] ech
    );
        path_mux = '0;
        unique case (m)
            BYPASS: path_mux = byp;
            FILTER: path_mux = flt;
            ECHO:   path_mux = ech;
            MUTE:   path_mux = '0;
        endcase
    endfunction

    assign in_s  = $signed(input_sample);
    assign flt_s = $signed(filter_sample);
    assign dly_s = $signed(dly_raw);

    // Overflow shows up as disagreeing top two bits of the widened sum.
    always_comb begin
        dly_sh   = dly_s >>> ECHO_SHIFT;
        echo_sum = (WIDTH + 1)'(in_s) + (WIDTH + 1)'(dly_sh);
        if (echo_sum[WIDTH] != echo_sum[WIDTH-1])
            echo_s = {echo_sum[WIDTH], {(WIDTH - 1){~echo_sum[WIDTH]}}};
        else
            echo_s = echo_sum[WIDTH-1:0];
    end

    always_comb begin
        cur_s = path_mux(mode_q, in_s, flt_s, echo_s);
        new_s = path_mux(target_q, in_s, flt_s, echo_s);
        wn    = $signed({2'b00, k_q});
        wo    = FADE_W - wn;
        mix   = PW'(cur_s) * PW'(wo) + PW'(new_s) * PW'(wn);
        mix_s = WIDTH'(mix >>> FADE_LOG2);
    end

    assign req = pend_vld_q ? pend_q : mode_e'(selector);

    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        target_d   = target_q;
        pend_d     = pend_q;
        pend_vld_d = 1'b0;
        k_d        = k_q;
        out_d      = cur_s;
        unique case (state_q)
            IDLE: begin
                if (req != mode_q) begin
                    state_d  = FADE;
                    target_d = req;
                    k_d      = '0;
                end
            end
            FADE: begin
                out_d  = mix_s;
                k_d    = k_q + 1'b1;
                pend_d = mode_e'(selector);
                if (k_q == K_LAST) begin
                    state_d    = IDLE;
                    mode_d     = target_q;
                    pend_vld_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge sample_clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            mode_q     <= BYPASS;
            target_q   <= BYPASS;
            pend_q     <= BYPASS;
            pend_vld_q <= 1'b0;
            k_q        <= '0;
            out_q      <= '0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            target_q   <= target_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            k_q        <= k_d;
            out_q      <= out_d;
        end
    end

    assign output_sample = out_q;
    assign mode_active   = mode_q;
    assign fading        = (state_q == FADE);

endmodule

// File: tb/tb_effect_router.sv
// Directed bench for effect_router: DEPTH=8, FADE_LOG2=2, ECHO_SHIFT=1,
// expected samples queued at drive time and popped after each edge.
module tb_effect_router;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] din = '0;
    logic [15:0] filt = '0;
    logic [1:0]  sel = '0;
    logic [15:0] dout;
    logic [1:0]  mode;
    logic        fade;

    int          vectors = 0;
    int          errors = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    effect_router #(
        .WIDTH      (16),
        .DEPTH      (8),
        .FADE_LOG2  (2),
        .ECHO_SHIFT (1)
    ) dut (
        .sample_clock  (clk),
        .reset         (rst_n),
        .input_sample  (din),
        .filter_sample (filt),
        .selector      (sel),
        .output_sample (dout),
        .mode_active   (mode),
        .fading        (fade)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] expv);
        vectors++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d",
                   tag, $signed(obs), $signed(expv));
        end
    endtask

    task automatic step(input string tag, input int i, input int f,
                        input logic [1:0] s, input int e, input logic ef);
        logic [15:0] expv;
        din  = 16'(i);
        filt = 16'(f);
        sel  = s;
        exp_q.push_back(16'(e));
        @(posedge clk);
        #1;
        expv = exp_q.pop_front();
        chk(tag, dout, expv);
        chk({tag, "_fading"}, {15'b0, fade}, {15'b0, ef});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        #2;
        chk("reset_out", dout, 16'd0);
        chk("reset_mode", {14'b0, mode}, 16'd0);
        chk("reset_fading", {15'b0, fade}, 16'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step("bypass_1000", 1000, 0, 2'b00, 1000, 1'b0);
        chk("bypass_mode", {14'b0, mode}, 16'd0);

        step("mute_pre", 400, 0, 2'b00, 400, 1'b0);
        step("mute_e0", 400, 0, 2'b11, 400, 1'b1);
        step("mute_k0", 400, 0, 2'b11, 400, 1'b1);
        step("mute_k1", 400, 0, 2'b11, 300, 1'b1);
        step("mute_k2", 400, 0, 2'b11, 200, 1'b1);
        step("mute_k3", 400, 0, 2'b11, 100, 1'b0);
        chk("mute_mode", {14'b0, mode}, 16'd3);
        step("mute_done", 400, 0, 2'b11, 0, 1'b0);

        step("unmute_e0", 400, 0, 2'b00, 0, 1'b1);
        step("unmute_k0", 400, 0, 2'b00, 0, 1'b1);
        step("unmute_k1", 400, 0, 2'b00, 100, 1'b1);
        step("unmute_k2", 400, 0, 2'b00, 200, 1'b1);
        step("unmute_k3", 400, 0, 2'b00, 300, 1'b0);
        step("unmute_done", 400, 0, 2'b00, 400, 1'b0);
        chk("unmute_mode", {14'b0, mode}, 16'd0);

        step("pend_e0", 400, 800, 2'b01, 400, 1'b1);
        step("pend_k0", 400, 800, 2'b01, 400, 1'b1);
        step("pend_k1", 400, 800, 2'b10, 500, 1'b1);
        step("pend_k2", 400, 800, 2'b11, 600, 1'b1);
        step("pend_k3", 400, 800, 2'b11, 700, 1'b0);
        chk("pend_mode1", {14'b0, mode}, 16'd1);
        step("pend2_e0", 400, 800, 2'b11, 800, 1'b1);
        step("pend2_k0", 400, 800, 2'b11, 800, 1'b1);
        step("pend2_k1", 400, 800, 2'b11, 600, 1'b1);
        step("pend2_k2", 400, 800, 2'b11, 400, 1'b1);
        step("pend2_k3", 400, 800, 2'b11, 200, 1'b0);
        chk("pend_mode3", {14'b0, mode}, 16'd3);
        step("pend_idle_a", 400, 800, 2'b11, 0, 1'b0);
        step("pend_idle_b", 400, 800, 2'b11, 0, 1'b0);
        chk("pend_no_echo", {14'b0, mode}, 16'd3);

        for (int n = 0; n < 8; n++)
            step("flush", 0, 0, 2'b11, 0, 1'b0);
        step("echo_e0", 0, 0, 2'b10, 0, 1'b1);
        for (int n = 0; n < 3; n++)
            step("echo_fade", 0, 0, 2'b10, 0, 1'b1);
        step("echo_k3", 0, 0, 2'b10, 0, 1'b0);
        chk("echo_mode", {14'b0, mode}, 16'd2);

        step("impulse", 16000, 0, 2'b10, 16000, 1'b0);
        for (int n = 0; n < 7; n++)
            step("impulse_gap", 0, 0, 2'b10, 0, 1'b0);
        step("impulse_echo", 0, 0, 2'b10, 8000, 1'b0);
        for (int n = 0; n < 8; n++)
            step("impulse_tail", 0, 0, 2'b10, 0, 1'b0);

        for (int n = 0; n < 8; n++)
            step("sat_fill", 30000, 0, 2'b10, 30000, 1'b0);
        for (int n = 0; n < 4; n++)
            step("sat_pos", 30000, 0, 2'b10, 32767, 1'b0);
        for (int n = 0; n < 8; n++)
            step("neg_mix", -30000, 0, 2'b10, -15000, 1'b0);
        for (int n = 0; n < 3; n++)
            step("sat_neg", -30000, 0, 2'b10, -32768, 1'b0);

        step("abort_e0", 100, 0, 2'b00, -14900, 1'b1);
        step("abort_k0", 100, 0, 2'b00, -14900, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_out", dout, 16'd0);
        chk("abort_fading", {15'b0, fade}, 16'd0);
        chk("abort_mode", {14'b0, mode}, 16'd0);
        din = '0;
        sel = 2'b10;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        step("mask_e0", 0, 0, 2'b10, 0, 1'b1);
        for (int n = 0; n < 3; n++)
            step("mask_fade", 0, 0, 2'b10, 0, 1'b1);
        step("mask_k3", 0, 0, 2'b10, 0, 1'b0);
        for (int n = 0; n < 3; n++)
            step("mask_idle", 0, 0, 2'b10, 0, 1'b0);
        chk("mask_mode", {14'b0, mode}, 16'd2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/effect_router.md
EFFECT_ROUTER -- requirements
Module: effect_router

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning signed sample width.
REQ-002 SHALL have parameter DEPTH, default 1024, meaning echo delay in samples (power of two, >=4).
REQ-003 SHALL have parameter FADE_LOG2, default 4, meaning crossfade length of 2^FADE_LOG2 samples.
REQ-004 SHALL have parameter ECHO_SHIFT, default 1, meaning echo gain of 2^-ECHO_SHIFT.
REQ-005 SHALL have port sample_clock  input  1  the single clock, one sample per rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port input_sample  input  WIDTH  signed dry sample.
REQ-008 SHALL have port filter_sample  input  WIDTH  signed sample from the external filter, same cycle as input_sample.
REQ-009 SHALL have port selector  input  2  requested mode: 00 bypass, 01 filter, 10 echo, 11 mute.
REQ-010 SHALL have port output_sample  output  WIDTH  signed registered result.
REQ-011 SHALL have port mode_active  output  2  mode currently fully applied.
REQ-012 SHALL have port fading  output  1  high while a crossfade runs.

Function
REQ-013 SHALL compute four path values each cycle: bypass=input_sample, filter=filter_sample, echo=sat(input_sample + (delayed >>> ECHO_SHIFT)), mute=0.
REQ-014 SHALL saturate echo sums to [-2^(WIDTH-1), 2^(WIDTH-1)-1]; no wrap-around.
REQ-015 SHALL write input_sample to a DEPTH-entry circular buffer every cycle; delayed = sample written exactly DEPTH cycles earlier; write pointer wraps DEPTH-1 -> 0.
REQ-016 SHALL treat delayed as 0 until DEPTH writes have completed since reset (fill flag).
REQ-017 SHALL register output_sample; latency one cycle from input_sample/filter_sample to output_sample.
REQ-018 SHALL use states IDLE and FADE; IDLE outputs the mode_active path.
REQ-019 SHALL, in IDLE when selector != mode_active, latch target=selector, clear counter k, enter FADE next cycle.
REQ-020 SHALL, in FADE, output (old*(2^F-k) + new*k) >>> F with full-precision signed intermediate, k incrementing 0..2^F-1 each cycle.
REQ-021 SHALL, after the k=2^F-1 cycle, set mode_active=target, fading=0, return to IDLE.
REQ-022 SHALL ignore selector changes during FADE except to record the latest value in a one-deep pending register; on return to IDLE a pending value differing from mode_active starts a new fade the next cycle.
REQ-023 SHALL not start a fade if the pending/selector value equals mode_active, including a request back to the old mode mid-fade after completion.
REQ-024 SHALL assert fading exactly in FADE cycles (2^F cycles per fade).

Reset
REQ-025 SHALL, on reset low, asynchronously clear output_sample to 0, mode_active to 00, fading to 0, state to IDLE, k, pending, write pointer and fill flag to 0.
REQ-026 SHALL abort any fade on reset mid-operation; buffer RAM contents need not clear (fill flag masks them).
REQ-027 SHALL resume normal operation on the first sample_clock edge after reset deasserts.

Structure
REQ-028 SHALL place mode encodings (BYPASS, FILTER, ECHO, MUTE) and state encodings in shared package effect_pkg.
REQ-029 SHALL implement the circular buffer, pointer and fill flag as sub-module echo_delay (params WIDTH, DEPTH; ports sample_clock, reset, din, dout).
REQ-030 SHALL keep saturation and crossfade arithmetic in effect_router.

Verification
REQ-031 Reset, selector=00, input_sample=1000 -> output_sample=1000 one cycle later, mode_active=00, fading=0.
REQ-032 DEPTH=8, ECHO_SHIFT=1: impulse 16000 then zeros, selector=10 held -> output 16000, then 0 for 7 samples, then 8000; before fill, delayed=0.
REQ-033 Echo saturation: input 30000 constant after fill, ECHO_SHIFT=1 -> output 32767, never negative.
REQ-034 FADE_LOG2=2, bypass input 400, switch to mute -> outputs 400,300,200,100, then 0; fading high 4 cycles; mode_active=11 afterwards.
REQ-035 During fade 00->01, toggle selector 10 then 11 -> after fade, one further fade to 11 (pending keeps latest); no fade to 10.
REQ-036 Assert reset low mid-fade -> output_sample=0, fading=0, mode_active=00 immediately, without a clock edge.
